stage_decode: RTL and testbench

Second pipeline stage of the in-order RV32I core, directly downstream of the fetch stage. It consumes the fetch pipeline register (instruction, PC, PC+4) and decodes the control signals and immediate. It reads the register file, which it owns, and registers everything into the decode/execute pipeline register. It also detects load-use hazards and inserts bubbles.

---
 rtl/core_pkg.sv | 89 ++++++++
 rtl/stage_decode_reg_file.sv | 49 ++++
 rtl/stage_decode.sv | 201 ++++++++++++++++++++
 tb/tb_stage_decode.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-type encodings,
// the decode/execute pipeline record and the immediate extraction helper.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_t;

    // Everything in the decode/execute register except the operand data.
    typedef struct packed {
        logic [31:0] instr_addr;
        logic [31:0] instr_addr_plus;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_t t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB over ADD and SRA over SRL; the caller qualifies it per opcode.
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stage_decode_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, x0 reads 0.
// Optional write-through on reads of the register being written: define DECODE_RF_BYPASS_EN.
module reg_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    // Contents are deliberately not reset; software must write before reading.
    logic [XLEN-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    logic [1:0][4:0]      raddr;
    logic [1:0][XLEN-1:0] rdata;

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;
    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic bypass_hit;
`ifdef DECODE_RF_BYPASS_EN
            assign bypass_hit = we_i && (waddr_i == raddr[gi]);
`else
            assign bypass_hit = 1'b0;
`endif
            assign rdata[gi] = (raddr[gi] == 5'd0) ? '0 :
                               bypass_hit          ? wdata_i :
                                                     mem_q[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/stage_decode.sv
// RV32I decode stage: control/immediate decode, register file read, load-use bubble insertion.
// Register-file write-through is enabled by defining DECODE_RF_BYPASS_EN.
module stage_decode #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_decode,
    input  logic            stall_decode,
    input  logic [31:0]     fetch_instr,
    input  logic [31:0]     fetch_instr_addr,
    input  logic [31:0]     fetch_instr_addr_plus,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard_stall,
    output logic [31:0]     decode_instr_addr,
    output logic [31:0]     decode_instr_addr_plus,
    output logic [XLEN-1:0] decode_rs1_data,
    output logic [XLEN-1:0] decode_rs2_data,
    output logic [4:0]      decode_rs1,
    output logic [4:0]      decode_rs2,
    output logic [4:0]      decode_rd,
    output logic [31:0]     decode_imm,
    output logic [2:0]      decode_funct3,
    output logic [3:0]      decode_alu_op,
    output logic            decode_alu_src,
    output logic            decode_mem_read,
    output logic            decode_mem_write,
    output logic            decode_reg_write,
    output logic            decode_branch,
    output logic            decode_jal,
    output logic            decode_jalr,
    output logic            decode_illegal
);
    import core_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    assign opcode  = fetch_instr[6:0];
    assign funct3  = fetch_instr[14:12];
    assign rs1_idx = fetch_instr[19:15];
    assign rs2_idx = fetch_instr[24:20];

    reg_file #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk      (clk),
        .we_i     (wb_reg_write),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_idx),
        .raddr2_i (rs2_idx),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    dec_t            dec_d, dec_q;
    logic [XLEN-1:0] rs1_data_d, rs2_data_d, rs1_data_q, rs2_data_q;
    imm_type_t       imm_type;
    logic            use_rs1, use_rs2, legal;

    always_comb begin
        dec_d      = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_type   = IMM_NONE;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        legal      = 1'b1;
        case (opcode)
            OP: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.alu_op    = alu_from_funct(funct3, fetch_instr[30]);
            end
            OP_IMM: begin
                use_rs1         = 1'b1;
                imm_type        = IMM_I;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                // Only the shift-right immediate form carries an alternate-op bit.
                dec_d.alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && fetch_instr[30]);
            end
            LOAD: begin
                use_rs1         = 1'b1;
                imm_type        = IMM_I;
                dec_d.alu_src   = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            STORE: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                imm_type        = IMM_S;
                dec_d.alu_src   = 1'b1;
                dec_d.mem_write = 1'b1;
            end
            BRANCH: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                imm_type     = IMM_B;
                dec_d.branch = 1'b1;
                dec_d.alu_op = ALU_SUB;
            end
            JAL: begin
                imm_type        = IMM_J;
                dec_d.jal       = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            JALR: begin
                use_rs1         = 1'b1;
                imm_type        = IMM_I;
                dec_d.jalr      = 1'b1;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            LUI: begin
                imm_type        = IMM_U;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.alu_op    = ALU_PASS_B;
            end
            AUIPC: begin
                imm_type        = IMM_U;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec_d.instr_addr      = fetch_instr_addr;
            dec_d.instr_addr_plus = fetch_instr_addr_plus;
            dec_d.rs1             = rs1_idx;
            dec_d.rs2             = rs2_idx;
            dec_d.rd              = fetch_instr[11:7];
            dec_d.funct3          = funct3;
            dec_d.imm             = imm_gen(fetch_instr, imm_type);
            rs1_data_d            = rf_rdata1;
            rs2_data_d            = rf_rdata2;
        end else if (fetch_instr != 32'd0) begin
            // An all-zero word is a fetch-side bubble, not an illegal instruction.
            dec_d.instr_addr      = fetch_instr_addr;
            dec_d.instr_addr_plus = fetch_instr_addr_plus;
            dec_d.illegal         = 1'b1;
        end
    end

    assign hazard_stall = !flush_decode && dec_q.mem_read && (dec_q.rd != 5'd0) &&
                          (((dec_q.rd == rs1_idx) && use_rs1) ||
                           ((dec_q.rd == rs2_idx) && use_rs2));

    always_ff @(posedge clk) begin
        if (rst || flush_decode) begin
            dec_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else if (stall_decode) begin
            dec_q      <= dec_q;
            rs1_data_q <= rs1_data_q;
            rs2_data_q <= rs2_data_q;
        end else if (hazard_stall) begin
            dec_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            dec_q      <= dec_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign decode_instr_addr      = dec_q.instr_addr;
    assign decode_instr_addr_plus = dec_q.instr_addr_plus;
    assign decode_rs1_data        = rs1_data_q;
    assign decode_rs2_data        = rs2_data_q;
    assign decode_rs1             = dec_q.rs1;
    assign decode_rs2             = dec_q.rs2;
    assign decode_rd              = dec_q.rd;
    assign decode_imm             = dec_q.imm;
    assign decode_funct3          = dec_q.funct3;
    assign decode_alu_op          = dec_q.alu_op;
    assign decode_alu_src         = dec_q.alu_src;
    assign decode_mem_read        = dec_q.mem_read;
    assign decode_mem_write       = dec_q.mem_write;
    assign decode_reg_write       = dec_q.reg_write;
    assign decode_branch          = dec_q.branch;
    assign decode_jal             = dec_q.jal;
    assign decode_jalr            = dec_q.jalr;
    assign decode_illegal         = dec_q.illegal;

endmodule

// File: tb/tb_stage_decode.sv
// Scoreboard bench for stage_decode: directed scenarios followed by randomized traffic,
// checked against a behavioural decode model and a shadow register array.
module tb_stage_decode;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_decode;
    logic        stall_decode;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_instr_addr;
    logic [31:0] fetch_instr_addr_plus;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard_stall;
    logic [31:0] decode_instr_addr;
    logic [31:0] decode_instr_addr_plus;
    logic [31:0] decode_rs1_data;
    logic [31:0] decode_rs2_data;
    logic [4:0]  decode_rs1;
    logic [4:0]  decode_rs2;
    logic [4:0]  decode_rd;
    logic [31:0] decode_imm;
    logic [2:0]  decode_funct3;
    logic [3:0]  decode_alu_op;
    logic        decode_alu_src;
    logic        decode_mem_read;
    logic        decode_mem_write;
    logic        decode_reg_write;
    logic        decode_branch;
    logic        decode_jal;
    logic        decode_jalr;
    logic        decode_illegal;

    stage_decode dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush_decode           (flush_decode),
        .stall_decode           (stall_decode),
        .fetch_instr            (fetch_instr),
        .fetch_instr_addr       (fetch_instr_addr),
        .fetch_instr_addr_plus  (fetch_instr_addr_plus),
        .wb_reg_write           (wb_reg_write),
        .wb_rd                  (wb_rd),
        .wb_data                (wb_data),
        .hazard_stall           (hazard_stall),
        .decode_instr_addr      (decode_instr_addr),
        .decode_instr_addr_plus (decode_instr_addr_plus),
        .decode_rs1_data        (decode_rs1_data),
        .decode_rs2_data        (decode_rs2_data),
        .decode_rs1             (decode_rs1),
        .decode_rs2             (decode_rs2),
        .decode_rd              (decode_rd),
        .decode_imm             (decode_imm),
        .decode_funct3          (decode_funct3),
        .decode_alu_op          (decode_alu_op),
        .decode_alu_src         (decode_alu_src),
        .decode_mem_read        (decode_mem_read),
        .decode_mem_write       (decode_mem_write),
        .decode_reg_write       (decode_reg_write),
        .decode_branch          (decode_branch),
        .decode_jal             (decode_jal),
        .decode_jalr            (decode_jalr),
        .decode_illegal         (decode_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        alu_src;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        haz;
        exp_t        st;
    } item_t;

    item_t       sb_q[$];
    exp_t        model_q;
    logic [31:0] regs[32];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Which source registers an opcode reads; unknown opcodes read none.
    function automatic logic [1:0] ref_uses(input logic [6:0] opc);
        if (opc == OP || opc == STORE || opc == BRANCH) return 2'b11;
        if (opc == OP_IMM || opc == LOAD || opc == JALR) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_legal(input logic [6:0] opc);
        return opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
    endfunction

    function automatic logic [31:0] rf_model(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
`ifdef DECODE_RF_BYPASS_EN
        if (we && wrd == idx) return wd;
`endif
        return regs[idx];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1v, input logic [31:0] r2v);
        exp_t               e;
        logic signed [31:0] sx;
        logic [6:0]         opc;
        logic [2:0]         f3;
        e   = '0;
        opc = ins[6:0];
        f3  = ins[14:12];
        if (ins == 32'd0) return e;
        e.pc  = pc;
        e.pcp = pc + 32'd4;
        if (!ref_legal(opc)) begin
            e.ill = 1'b1;
            return e;
        end
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.f3  = f3;
        e.r1d = r1v;
        e.r2d = r2v;
        case (opc)
            OP: begin
                e.rw = 1'b1; e.alu = ref_alu(f3, ins[30]);
            end
            OP_IMM: begin
                sx = $signed(ins[31:20]); e.imm = sx;
                e.rw = 1'b1; e.alu_src = 1'b1; e.alu = ref_alu(f3, f3 == 3'd5 && ins[30]);
            end
            LOAD: begin
                sx = $signed(ins[31:20]); e.imm = sx;
                e.rw = 1'b1; e.alu_src = 1'b1; e.mrd = 1'b1;
            end
            STORE: begin
                sx = $signed({ins[31:25], ins[11:7]}); e.imm = sx;
                e.alu_src = 1'b1; e.mwr = 1'b1;
            end
            BRANCH: begin
                sx = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); e.imm = sx;
                e.br = 1'b1; e.alu = ALU_SUB;
            end
            JAL: begin
                sx = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); e.imm = sx;
                e.jal = 1'b1; e.rw = 1'b1;
            end
            JALR: begin
                sx = $signed(ins[31:20]); e.imm = sx;
                e.jalr = 1'b1; e.rw = 1'b1; e.alu_src = 1'b1;
            end
            LUI: begin
                e.imm = {ins[31:12], 12'd0}; e.rw = 1'b1; e.alu_src = 1'b1; e.alu = ALU_PASS_B;
            end
            default: begin
                e.imm = {ins[31:12], 12'd0}; e.rw = 1'b1; e.alu_src = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs and queue the expected hazard flag and next register contents.
    task automatic step(input logic r, input logic fl, input logic st, input logic [31:0] ins,
                        input logic [31:0] pc, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        item_t      it;
        logic [1:0] u;
        logic       haz;
        exp_t       nxt;
        @(negedge clk);
        rst                   = r;
        flush_decode          = fl;
        stall_decode          = st;
        fetch_instr           = ins;
        fetch_instr_addr      = pc;
        fetch_instr_addr_plus = pc + 32'd4;
        wb_reg_write          = we;
        wb_rd                 = wrd;
        wb_data               = wd;
        u   = ref_uses(ins[6:0]);
        haz = !fl && model_q.mrd && (model_q.rd != 5'd0) &&
              ((model_q.rd == ins[19:15] && u[0]) || (model_q.rd == ins[24:20] && u[1]));
        if (r || fl)   nxt = '0;
        else if (st)   nxt = model_q;
        else if (haz)  nxt = '0;
        else           nxt = ref_decode(ins, pc, rf_model(ins[19:15], we, wrd, wd),
                                        rf_model(ins[24:20], we, wrd, wd));
        it.instr = ins;
        it.haz   = haz;
        it.st    = nxt;
        sb_q.push_back(it);
        model_q = nxt;
        if (we && wrd != 5'd0) regs[wrd] = wd;
    endtask

    // Monitor: hazard flag just before the edge, decode register just after it.
    initial begin
        item_t it;
        exp_t  act;
        int    n = 0;
        forever begin
            @(negedge clk);
            #4;
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                checks++;
                if (hazard_stall !== it.haz) begin
                    errors++;
                    $display("FAIL hazard_stall txn %0d instr=%h: got %b expected %b",
                             n, it.instr, hazard_stall, it.haz);
                end
                @(posedge clk);
                #1;
                act = {decode_instr_addr, decode_instr_addr_plus, decode_rs1_data, decode_rs2_data,
                       decode_rs1, decode_rs2, decode_rd, decode_imm, decode_funct3, decode_alu_op,
                       decode_alu_src, decode_mem_read, decode_mem_write, decode_reg_write,
                       decode_branch, decode_jal, decode_jalr, decode_illegal};
                checks++;
                if (act !== it.st) begin
                    errors++;
                    $display("FAIL decode_reg txn %0d instr=%h: got %h expected %h",
                             n, it.instr, act, it.st);
                end
                $display("txn %0d instr=%h haz=%b pc=%h imm=%h alu=%0d ill=%b",
                         n, it.instr, it.haz, it.st.pc, it.st.imm, it.st.alu, it.st.ill);
                n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  opcs[11];
        opcs = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, 7'h7F, 7'h00};
        model_q = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst = 1'b1; flush_decode = 1'b0; stall_decode = 1'b0; fetch_instr = 32'd0;
        fetch_instr_addr = 32'd0; fetch_instr_addr_plus = 32'd4;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

        step(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);
        step(1, 0, 0, 32'd0, 32'd0, 0, 0, 0);
        // Fill the register file under a held decode register.
        for (int i = 1; i < 32; i++) step(0, 0, 1, $urandom, 32'h100, 1, 5'(i), $urandom);

        step(0, 0, 0, 32'h00500093, 32'h10, 0, 0, 0);          // addi x1,x0,5
        step(0, 0, 0, 32'h0000A103, 32'h14, 0, 0, 0);          // lw x2,0(x1)
        step(0, 0, 0, 32'h001101B3, 32'h18, 0, 0, 0);          // add x3,x2,x1 -> stall
        step(0, 0, 0, 32'h001101B3, 32'h18, 0, 0, 0);          // add registers
        step(0, 0, 0, 32'hFE208CE3, 32'h1C, 0, 0, 0);          // beq x1,x2,-8
        step(0, 1, 0, 32'hFE208CE3, 32'h1C, 0, 0, 0);          // same under flush
        step(0, 0, 0, 32'h00028313, 32'h20, 1, 5'd5, 32'hDEADBEEF); // addi x6,x5,0 during wb x5
        step(0, 0, 0, 32'h00028313, 32'h24, 0, 0, 0);
        step(0, 0, 0, 32'h00000393, 32'h28, 1, 5'd0, 32'h1234);    // write x0 while reading x0
        step(0, 0, 0, 32'h00000393, 32'h2C, 0, 0, 0);
        step(0, 0, 0, 32'h0000007F, 32'h30, 0, 0, 0);          // unknown opcode
        step(0, 0, 0, 32'h00000000, 32'h34, 0, 0, 0);          // fetch bubble
        step(0, 0, 0, 32'h0000A103, 32'h38, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom, 32'h40 + 32'(i * 4), 1, 5'd9, $urandom);
        step(1, 0, 1, 32'h00500093, 32'h50, 0, 0, 0);          // reset during stall
        step(0, 0, 0, 32'h00500093, 32'h54, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            ins       = $urandom;
            ins[6:0]  = opcs[$urandom_range(0, 10)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if (ins[6:0] == 7'h00) ins = 32'd0;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 ins, {$urandom, 2'b00}, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
